// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath select and enable.
module multicycle_controller #(
    parameter bit STRICT_DECODE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        CarryOut,
    input  logic        Overflow,
    input  logic        Sign,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        IllegalInstr,
    output logic [3:0]  StateDbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALRADR  = 4'd10,
        S_JALRJMP  = 4'd11,
        S_BRANCH   = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    state_t      state_r;
    state_t      next_state_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic        legal_s;
    logic        pcwrite_s;
    logic        adrsrc_s;
    logic        irwrite_s;
    logic        regwrite_s;
    logic        memwrite_s;
    logic        illegal_s;
    logic [1:0]  resultsrc_s;
    logic [1:0]  alusrca_s;
    logic [1:0]  alusrcb_s;
    logic [3:0]  alucontrol_s;
    logic [2:0]  immsrc_s;
    logic        unused_s;

    assign opcode_s = Instr[6:0];
    assign funct3_s = Instr[14:12];
    assign funct7_s = Instr[31:25];
    assign unused_s = ^{Instr[24:15], Instr[11:7]};

    // Only add/sub and srl/sra (and srli/srai) are distinguished by funct7 bit 5.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic is_rtype);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic c, input logic v, input logic s);
        logic t;
        case (f3)
            3'b000:  t = z;
            3'b001:  t = !z;
            3'b100:  t = s ^ v;
            3'b101:  t = !(s ^ v);
            3'b110:  t = !c;
            3'b111:  t = c;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Relaxed decoding still rejects unknown opcodes and branch funct3 010/011.
    function automatic logic instr_legal(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
        logic ok;
        case (op)
            OP_LOAD, OP_STORE: ok = !STRICT_DECODE || (f3 == 3'b010);
            OP_RTYPE:  ok = !STRICT_DECODE || (f7 == 7'h00) ||
                            ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
            OP_IMM: begin
                if (f3 == 3'b001) begin
                    ok = !STRICT_DECODE || (f7 == 7'h00);
                end else if (f3 == 3'b101) begin
                    ok = !STRICT_DECODE || (f7 == 7'h00) || (f7 == 7'h20);
                end else begin
                    ok = 1'b1;
                end
            end
            OP_JALR:   ok = !STRICT_DECODE || (f3 == 3'b000);
            OP_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
            OP_JAL, OP_LUI, OP_AUIPC: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign legal_s = instr_legal(opcode_s, funct3_s, funct7_s);

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        immsrc_s = 3'b000;
        case (opcode_s)
            OP_LOAD, OP_IMM, OP_JALR: immsrc_s = 3'b000;
            OP_STORE:                 immsrc_s = 3'b001;
            OP_BRANCH:                immsrc_s = 3'b010;
            OP_JAL:                   immsrc_s = 3'b011;
            OP_LUI, OP_AUIPC:         immsrc_s = 3'b100;
            default:                  immsrc_s = 3'b000;
        endcase
    end

    // Next-state and per-state control decode.
    always_comb begin
        pcwrite_s    = 1'b0;
        adrsrc_s     = 1'b0;
        irwrite_s    = 1'b0;
        regwrite_s   = 1'b0;
        memwrite_s   = 1'b0;
        illegal_s    = 1'b0;
        resultsrc_s  = 2'b00;
        alusrca_s    = 2'b00;
        alusrcb_s    = 2'b00;
        alucontrol_s = ALU_ADD;
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                irwrite_s    = 1'b1;
                alusrcb_s    = 2'b10;
                resultsrc_s  = 2'b10;
                pcwrite_s    = 1'b1;
                next_state_s = S_DECODE;
            end
            S_DECODE: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
                if (!legal_s) begin
                    illegal_s    = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    case (opcode_s)
                        OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
                        OP_RTYPE:  next_state_s = S_EXECR;
                        OP_IMM:    next_state_s = S_EXECI;
                        OP_JAL:    next_state_s = S_JAL;
                        OP_JALR:   next_state_s = S_JALRADR;
                        OP_BRANCH: next_state_s = S_BRANCH;
                        OP_LUI:    next_state_s = S_LUI;
                        OP_AUIPC:  next_state_s = S_ALUWB;
                        default:   next_state_s = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alusrca_s    = 2'b10;
                alusrcb_s    = 2'b01;
                next_state_s = (opcode_s == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc_s     = 1'b1;
                next_state_s = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc_s  = 2'b01;
                regwrite_s   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc_s     = 1'b1;
                memwrite_s   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_EXECR: begin
                alusrca_s    = 2'b10;
                alucontrol_s = alu_decode(funct3_s, funct7_s[5], 1'b1);
                next_state_s = S_ALUWB;
            end
            S_EXECI: begin
                alusrca_s    = 2'b10;
                alusrcb_s    = 2'b01;
                alucontrol_s = alu_decode(funct3_s, funct7_s[5], 1'b0);
                next_state_s = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_s   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_JAL, S_JALRJMP: begin
                // PC takes the target held in ALUOut while the ALU forms the link value.
                alusrca_s    = 2'b01;
                alusrcb_s    = 2'b10;
                pcwrite_s    = 1'b1;
                next_state_s = S_ALUWB;
            end
            S_JALRADR: begin
                alusrca_s    = 2'b10;
                alusrcb_s    = 2'b01;
                next_state_s = S_JALRJMP;
            end
            S_BRANCH: begin
                alusrca_s    = 2'b10;
                alucontrol_s = ALU_SUB;
                pcwrite_s    = branch_taken(funct3_s, Zero, CarryOut, Overflow, Sign);
                next_state_s = S_FETCH;
            end
            S_LUI: begin
                alusrcb_s    = 2'b01;
                alucontrol_s = ALU_PASSB;
                next_state_s = S_ALUWB;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    assign PCWrite      = pcwrite_s  & ~reset;
    assign IRWrite      = irwrite_s  & ~reset;
    assign RegWrite     = regwrite_s & ~reset;
    assign MemWrite     = memwrite_s & ~reset;
    assign IllegalInstr = illegal_s  & ~reset;
    assign AdrSrc       = adrsrc_s;
    assign ResultSrc    = resultsrc_s;
    assign ALUSrcA      = alusrca_s;
    assign ALUSrcB      = alusrcb_s;
    assign ALUControl   = alucontrol_s;
    assign ImmSrc       = immsrc_s;
    assign StateDbg     = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction's state path and
// per-cycle controls are predicted from the instruction-class rules.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = 32'h0000_0000;
    logic        Zero = 1'b0;
    logic        CarryOut = 1'b0;
    logic        Overflow = 1'b0;
    logic        Sign = 1'b0;
    logic        PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, IllegalInstr;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl, StateDbg;

    int checks = 0;
    int errors = 0;
    int path_q[$];

    multicycle_controller #(.STRICT_DECODE(1'b1)) dut (
        .clk(clk), .reset(reset), .Instr(Instr),
        .Zero(Zero), .CarryOut(CarryOut), .Overflow(Overflow), .Sign(Sign),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .IllegalInstr(IllegalInstr), .StateDbg(StateDbg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_legal(input logic [31:0] ins);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        case (op)
            7'h03, 7'h23: return f3 == 3'd2;
            7'h33: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            7'h13: begin
                if (f3 == 3'd1) return f7 == 7'h00;
                if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
                return 1'b1;
            end
            7'h67: return f3 == 3'd0;
            7'h63: return (f3 != 3'd2) && (f3 != 3'd3);
            7'h6F, 7'h37, 7'h17: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected state walk for one instruction, FETCH through its last state.
    function automatic void build_path(input logic [31:0] ins);
        path_q = '{0, 1};
        if (model_legal(ins)) begin
            case (ins[6:0])
                7'h03: path_q = '{0, 1, 2, 3, 4};
                7'h23: path_q = '{0, 1, 2, 5};
                7'h33: path_q = '{0, 1, 6, 8};
                7'h13: path_q = '{0, 1, 7, 8};
                7'h6F: path_q = '{0, 1, 9, 8};
                7'h67: path_q = '{0, 1, 10, 11, 8};
                7'h63: path_q = '{0, 1, 12};
                7'h37: path_q = '{0, 1, 13, 8};
                7'h17: path_q = '{0, 1, 8};
                default: path_q = '{0, 1};
            endcase
        end
    endfunction

    function automatic logic [3:0] model_alu(input logic [31:0] ins, input bit is_r);
        case (ins[14:12])
            3'd0: return (is_r && ins[30]) ? 4'd1 : 4'd0;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return ins[30] ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic bit model_taken(input logic [2:0] f3, input logic [3:0] flg);
        bit z = flg[3], c = flg[2], v = flg[1], s = flg[0];
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return s != v;
            3'd5: return s == v;
            3'd6: return !c;
            3'd7: return c;
            default: return 1'b0;
        endcase
    endfunction

    // Packed {PCWrite,AdrSrc,IRWrite,RegWrite,MemWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,IllegalInstr}.
    function automatic logic [18:0] model_outs(input int st, input logic [31:0] ins, input logic [3:0] flg);
        logic pcw = 0, adr = 0, irw = 0, rgw = 0, mw = 0, ill = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0;
        logic [2:0] imm = 0;
        logic [3:0] alu = 0;
        case (ins[6:0])
            7'h23: imm = 3'd1;
            7'h63: imm = 3'd2;
            7'h6F: imm = 3'd3;
            7'h37, 7'h17: imm = 3'd4;
            default: imm = 3'd0;
        endcase
        case (st)
            0:  begin irw = 1; pcw = 1; sb = 2; rs = 2; end
            1:  begin sa = 1; sb = 1; ill = !model_legal(ins); end
            2, 10: begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rgw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; alu = model_alu(ins, 1'b1); end
            7:  begin sa = 2; sb = 1; alu = model_alu(ins, 1'b0); end
            8:  rgw = 1;
            9, 11: begin sa = 1; sb = 2; pcw = 1; end
            12: begin sa = 2; alu = 4'd1; pcw = model_taken(ins[14:12], flg); end
            13: begin sb = 1; alu = 4'd10; end
            default: ;
        endcase
        return {pcw, adr, irw, rgw, mw, rs, sa, sb, imm, alu, ill};
    endfunction

    // Called just after a falling edge with the DUT in FETCH; returns likewise.
    task automatic run_instr(input logic [31:0] ins, input bit fixed, input logic [3:0] fflg);
        logic [3:0] flg;
        build_path(ins);
        foreach (path_q[i]) begin
            flg = fixed ? fflg : 4'($urandom);
            Instr = ins;
            {Zero, CarryOut, Overflow, Sign} = flg;
            #1;
            check_val($sformatf("state %h c%0d", ins, i), {28'd0, StateDbg}, 32'(path_q[i]));
            check_val($sformatf("outs %h st%0d", ins, path_q[i]),
                      {13'd0, PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, ResultSrc,
                       ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr},
                      {13'd0, model_outs(path_q[i], ins, flg)});
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r = $urandom;
        logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};
        case ($urandom_range(0, 11))
            0:  return {r[31:15], 3'd2, r[11:7], 7'h03};
            1:  return {r[31:15], 3'd2, r[11:7], 7'h23};
            2:  return {f7s[$urandom_range(0, 2)], r[24:15], r[14:12], r[11:7], 7'h33};
            3:  return {f7s[$urandom_range(0, 2)], r[24:15], r[14:12], r[11:7], 7'h13};
            4:  return {r[31:7], 7'h6F};
            5:  return {r[31:15], ($urandom_range(0, 3) == 0) ? r[14:12] : 3'd0, r[11:7], 7'h67};
            6:  return {r[31:7], 7'h63};
            7:  return {r[31:7], 7'h37};
            8:  return {r[31:7], 7'h17};
            9:  return r;
            10: return {r[31:7], r[5] ? 7'h03 : 7'h23};
            default: return {r[31:7], 7'h33};
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_val("reset_state", {28'd0, StateDbg}, 32'd0);
        check_val("reset_enables", {27'd0, PCWrite, IRWrite, RegWrite, MemWrite, IllegalInstr}, 32'd0);
        reset = 1'b0;

        run_instr(32'h00A2_8133, 1'b0, 4'h0);
        run_instr(32'h0082_A183, 1'b0, 4'h0);
        run_instr(32'h0032_A423, 1'b0, 4'h0);
        run_instr(32'h00A2_E063, 1'b1, 4'b0000);
        run_instr(32'h00A2_E063, 1'b1, 4'b0100);
        run_instr(32'h0002_80E7, 1'b0, 4'h0);
        run_instr(32'h0000_007F, 1'b0, 4'h0);
        run_instr(32'h02A2_8133, 1'b0, 4'h0);

        // Reset held for two edges while a store sits in MEMWRITE.
        Instr = 32'h0032_A423;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("rst_pre_state", {28'd0, StateDbg}, 32'(i));
            @(negedge clk);
        end
        #1;
        check_val("rst_in_memwrite", {28'd0, StateDbg}, 32'd5);
        reset = 1'b1;
        #1;
        check_val("rst_gated_writes", {29'd0, MemWrite, RegWrite, PCWrite}, 32'd0);
        @(negedge clk);
        #1;
        check_val("rst_held_state", {28'd0, StateDbg}, 32'd0);
        check_val("rst_held_enables", {27'd0, PCWrite, IRWrite, RegWrite, MemWrite, IllegalInstr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("post_rst_state", {28'd0, StateDbg}, 32'd0);
        check_val("post_rst_fetch", {30'd0, IRWrite, PCWrite}, 32'd3);

        for (int n = 0; n < 200; n++) begin
            run_instr(gen_instr(), 1'b0, 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I datapath; sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction.
- Drives every datapath select and enable (PCWrite, AdrSrc, IRWrite, ResultSrc, ALUControl, ALUSrcA/B, ImmSrc, RegWrite) plus MemWrite to the memory module.
- Consumes the latched Instr and the ALU flags.

Parameters:
STRICT_DECODE, 1, 1 = an unsupported funct3/funct7 combination is treated as an illegal instruction; 0 = funct7 ignored except bit 5 for sub/sra/srai.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high.
Instr  input  32  instruction register output.
Zero, CarryOut, Overflow, Sign  input  1 each  ALU flags, valid combinationally for the current SrcA/SrcB.
PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite  output  1 each  datapath/memory enables and selects.
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
ALUSrcA  output  2  00 PC, 01 OldPC, 10 A.
ALUSrcB  output  2  00 WriteData, 01 ImmExt, 10 constant 4.
ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
ALUControl  output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB.
IllegalInstr  output  1  one-cycle pulse in DECODE on an unsupported opcode or function field.
StateDbg  output  4  current state encoding.

Behaviour:
- One clock: clk. Reset is synchronous and active-high: reset.
- Reset behaviour:
  - A reset sampled high forces state to FETCH(0) at the edge.
  - While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and IllegalInstr are forced to 0.
  - A reset mid-instruction abandons the instruction; no partial register or memory write occurs after the reset edge.
- Output defaults: all selects 00/0000 and all enables 0 unless listed below.
- ImmSrc is decoded from Instr[6:0] in every state: I for load/op-imm/jalr, S for store, B for branch, J for jal, U for lui/auipc, 000 otherwise.
- States (StateDbg) and outputs:
  - FETCH 0: AdrSrc=0, IRWrite=1, SrcA=PC, SrcB=4, add, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE 1: SrcA=OldPC, SrcB=ImmExt, add (ALUOut <= OldPC+imm, the branch/jal/auipc target).
    - lw/sw → MEMADR; R-type → EXECR; op-imm → EXECI; jal → JAL; jalr → JALRADR; branch → BRANCH; lui → LUI; auipc → ALUWB.
    - Any other opcode → FETCH with IllegalInstr=1 and no writes.
  - MEMADR 2: SrcA=A, SrcB=ImmExt, add. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD 3: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB 4: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE 5: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECR 6: SrcA=A, SrcB=WriteData, ALUControl from funct3/funct7[5]. Next: ALUWB.
  - EXECI 7: SrcA=A, SrcB=ImmExt, ALUControl from funct3; funct7[5] is consulted only for funct3=101. Next: ALUWB.
  - ALUWB 8: ResultSrc=00, RegWrite=1. Next: FETCH.
  - JAL 9: SrcA=OldPC, SrcB=4, add, ResultSrc=00, PCWrite=1 (PC <= target; ALUOut <= OldPC+4). Next: ALUWB.
  - JALRADR 10: SrcA=A, SrcB=ImmExt, add. Next: JALRJMP.
  - JALRJMP 11: same outputs as JAL. Next: ALUWB. The target LSB is not masked; software guarantees alignment.
  - BRANCH 12: SrcA=A, SrcB=WriteData, sub, ResultSrc=00, PCWrite=taken. Next: FETCH.
  - LUI 13: SrcB=ImmExt, passB. Next: ALUWB.
- Branch condition, by funct3:
  - beq: Zero; bne: !Zero.
  - blt: Sign^Overflow; bge: !(Sign^Overflow).
  - bltu: !CarryOut; bgeu: CarryOut (CarryOut=1 means A>=B unsigned).
  - funct3 010/011: illegal, handled in DECODE.
- Cycle counts (instruction accepted to next FETCH):
  - lw 5; sw 4; R/I-type 4; jal 4; jalr 5; branch 3; lui 4; auipc 3; illegal 2.
- Unreachable state encodings (14, 15) return to FETCH on the next edge with all enables 0.

Test Plan:
- Reset held 2 cycles mid-MEMWRITE → StateDbg=0; MemWrite, RegWrite, PCWrite = 0 during reset; first post-reset cycle shows IRWrite=1, PCWrite=1.
- Instr=0x00A28133 (add x2,x5,x10) → states 0,1,6,8,0; EXECR ALUControl=0000, ALUSrcA=10, ALUSrcB=00; RegWrite high only in state 8.
- Instr=0x0082A183 (lw) then 0x0032A423 (sw) → lw states 0,1,2,3,4 (ResultSrc=01 in 4); sw states 0,1,2,5 with MemWrite=1 and AdrSrc=1 only in 5; ImmSrc=000 then 001.
- bltu with CarryOut=0, then CarryOut=1 → PCWrite=1 in BRANCH for the first, 0 for the second; ALUControl=0001.
- jalr (0x000280E7) → states 0,1,10,11,8; PCWrite=1 in 11 with ALUSrcA=01, ALUSrcB=10; RegWrite=1 in 8.
- Instr=0x0000007F, and R-type with funct7=0x01 under STRICT_DECODE=1 → IllegalInstr pulses for 1 cycle in DECODE; next state FETCH; no RegWrite/MemWrite.
